// File: rtl/rv_csr_pkg.sv
// Shared types, CSR address constants and the read-modify-write merge used by
// the Zicsr execute sequencer.
package rv_csr_pkg;

    typedef enum logic [2:0] {
        CSR_OP_RSV0 = 3'b000,
        CSRRW       = 3'b001,
        CSRRS       = 3'b010,
        CSRRC       = 3'b011,
        CSR_OP_RSV4 = 3'b100,
        CSRRWI      = 3'b101,
        CSRRSI      = 3'b110,
        CSRRCI      = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } csr_state_e;

    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_CYCLE    = 12'hc00;
    localparam logic [11:0] CSR_TIME     = 12'hc01;
    localparam logic [11:0] CSR_INSTRET  = 12'hc02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hc80;
    localparam logic [11:0] CSR_TIMEH    = 12'hc81;
    localparam logic [11:0] CSR_INSTRETH = 12'hc82;

    // kind is funct3[1:0]: 01 write, 10 set, 11 clear. Computed at 64 bits;
    // RV32 callers keep the low half.
    function automatic logic [63:0] csr_merge(input logic [1:0]  kind,
                                              input logic [63:0] old_value,
                                              input logic [63:0] operand);
        case (kind)
            2'b10:   csr_merge = old_value | operand;
            2'b11:   csr_merge = old_value & ~operand;
            default: csr_merge = operand;
        endcase
    endfunction

endpackage

// File: rtl/rv_csr_exec.sv
// Zicsr execute-stage sequencer: accepts one CSR instruction, performs the
// read-modify-write against the CSR file and hands rd/illegal to writeback.
module rv_csr_exec
    import rv_csr_pkg::*;
#(
    parameter bit rv64 = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_funct3,
    input  logic [11:0]                 in_csr,
    input  logic [4:0]                  in_rs1_index,
    input  logic [(rv64 ? 64 : 32)-1:0] in_rs1_value,
    input  logic [4:0]                  in_rd,
    output logic [11:0]                 csr,
    output logic                        load,
    output logic                        store,
    output logic [(rv64 ? 64 : 32)-1:0] store_value,
    input  logic                        sigill,
    input  logic [(rv64 ? 64 : 32)-1:0] load_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4:0]                  out_rd,
    output logic [(rv64 ? 64 : 32)-1:0] out_rd_value,
    output logic                        out_sigill
);

    localparam int xlen = rv64 ? 64 : 32;

    csr_state_e         state, state_next;
    logic               sigill_p2, sigill_next;

    logic [1:0]         kind_p0;
    logic [11:0]        csr_p0;
    logic [4:0]         rd_p0;
    logic [xlen-1:0]    operand_p0;
    logic               do_read_p0;
    logic               do_write_p0;
    logic [xlen-1:0]    old_p1;

    logic               in_do_read;
    logic               in_do_write;
    logic [xlen-1:0]    in_operand;
    logic [63:0]        merged;

    assign in_do_read  = !(in_funct3[1:0] == 2'b01 && in_rd == 5'd0);
    assign in_do_write = (in_funct3[1:0] == 2'b01) || (in_rs1_index != 5'd0);
    assign in_operand  = in_funct3[2] ? xlen'(in_rs1_index) : in_rs1_value;
    assign merged      = csr_merge(kind_p0, 64'(old_p1), 64'(operand_p0));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            sigill_p2 <= 1'b0;
        end else begin
            state     <= state_next;
            sigill_p2 <= sigill_next;
        end
    end

    // Stage 0: instruction capture at acceptance
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && in_valid) begin
            kind_p0     <= in_funct3[1:0];
            csr_p0      <= in_csr;
            rd_p0       <= in_rd;
            operand_p0  <= in_operand;
            do_read_p0  <= in_do_read;
            do_write_p0 <= in_do_write;
        end
    end

    // Stage 1: old CSR value captured during READ
    always_ff @(posedge clock) begin
        if (state == ST_READ) begin
            old_p1 <= do_read_p0 ? load_value : '0;
        end
    end

    always_comb begin
        state_next   = state;
        sigill_next  = sigill_p2;
        in_ready     = 1'b0;
        csr          = '0;
        load         = 1'b0;
        store        = 1'b0;
        store_value  = '0;
        out_valid    = 1'b0;
        out_rd       = '0;
        out_rd_value = '0;
        out_sigill   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Reserved encodings and writes to read-only space fail
                    // without touching the CSR file.
                    if (in_funct3[1:0] == 2'b00 ||
                        (in_do_write && in_csr[11:10] == 2'b11)) begin
                        sigill_next = 1'b1;
                        state_next  = ST_DONE;
                    end else begin
                        sigill_next = 1'b0;
                        state_next  = ST_READ;
                    end
                end
            end
            ST_READ: begin
                csr        = csr_p0;
                load       = do_read_p0;
                state_next = do_write_p0 ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                csr         = csr_p0;
                store       = 1'b1;
                store_value = merged[xlen-1:0];
                sigill_next = sigill;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                out_valid    = 1'b1;
                out_rd       = rd_p0;
                out_sigill   = sigill_p2;
                out_rd_value = sigill_p2 ? '0 : old_p1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
